// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory bus responder and its register bank.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCAL   = 2'd1,
    DDR_CMD = 2'd2,
    DDR_RD  = 2'd3
  } bus_state_e;

  localparam int          LOCAL_SEL_BIT  = 25;
  localparam int          REG_COUNT_DEF  = 8;
  localparam int          STATUS_REG_IDX = REG_COUNT_DEF - 1;
  localparam logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF;

  // The status register always occupies the last slot of the bank.
  function automatic int status_reg_idx(input int reg_count);
    return reg_count - 1;
  endfunction

endpackage

// File: rtl/mem_bus_regbank.sv
// Local register bank: scratch registers, LED register (index 0) and the
// read-only status word holding the sticky bus error and a transaction counter.
module mem_bus_regbank
  import mem_bus_pkg::*;
#(
  parameter int REG_COUNT = REG_COUNT_DEF,
  parameter int IDX_W     = $clog2(REG_COUNT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  input  logic             txn_done,
  input  logic             set_error,
  output logic [31:0]      rdata,
  output logic [3:0]       led_reg,
  output logic             bus_error
);

  localparam int STAT_IDX = status_reg_idx(REG_COUNT);

  logic [31:0] regs [REG_COUNT];
  logic [15:0] txn_count;
  logic        stat_sel;

  assign stat_sel = (idx == IDX_W'(STAT_IDX));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      txn_count <= '0;
      bus_error <= 1'b0;
    end else begin
      if (wr_en && !stat_sel) regs[idx] <= wdata;
      // Any write to the status slot is a clear command; it wins over new events.
      if (wr_en && stat_sel) begin
        txn_count <= '0;
        bus_error <= 1'b0;
      end else begin
        if (set_error) bus_error <= 1'b1;
        if (txn_done && (txn_count != 16'hFFFF)) txn_count <= txn_count + 16'd1;
      end
    end
  end

  assign rdata   = stat_sel ? {txn_count, 15'd0, bus_error} : regs[idx];
  assign led_reg = regs[0][3:0];

endmodule

// File: rtl/mem_bus_responder.sv
// Responder for the processor memory interface: local register bank or DDR command port.
// Optional DDR wait timeout enabled by defining BUS_TIMEOUT_EN.
//   state   | meaning
//   IDLE    | waiting for a single read or write request
//   LOCAL   | one-cycle register bank access
//   DDR_CMD | command presented to DDR, waiting for accept
//   DDR_RD  | read accepted, waiting for read data strobe
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int REG_COUNT      = 8,
  parameter int DDR_ADDR_W     = 25,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memory_read_req,
  input  logic                  memory_write_req,
  input  logic [25:0]           memory_addr,
  input  logic [31:0]           memory_data_write,
  output logic [31:0]           memory_data_read,
  output logic                  memory_busy,
  output logic                  ddr_cmd_valid,
  input  logic                  ddr_cmd_ready,
  output logic                  ddr_cmd_we,
  output logic [DDR_ADDR_W-1:0] ddr_cmd_addr,
  output logic [31:0]           ddr_cmd_wdata,
  input  logic [31:0]           ddr_rdata,
  input  logic                  ddr_rdata_valid,
  output logic [3:0]            led_reg,
  output logic                  bus_error
);

  localparam int IDX_W = $clog2(REG_COUNT);

  if (REG_COUNT < 4 || (REG_COUNT & (REG_COUNT - 1)) != 0 || TIMEOUT_CYCLES < 2)
  begin : g_param_check
    $error("mem_bus_responder: unsupported parameter values");
  end

  bus_state_e            state, state_next;
  logic [DDR_ADDR_W-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  we_q;
  logic                  req_one, req_both, accept, rd_done, timeout, expire;
  logic                  txn_done, set_error;
  logic [31:0]           rb_rdata;

  assign req_one  = memory_read_req ^ memory_write_req;
  assign req_both = memory_read_req & memory_write_req;
  assign accept   = (state == DDR_CMD) & ddr_cmd_ready;
  assign rd_done  = (state == DDR_RD) & ddr_rdata_valid;
  // A completion landing on the terminal cycle takes priority over the timeout.
  assign expire   = timeout & ~accept & ~rd_done;

`ifdef BUS_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  logic [TMR_W-1:0] tmr;

  always_ff @(posedge clk) begin
    if (reset)                    tmr <= '0;
    else if (state_next != state) tmr <= TMR_W'(TIMEOUT_CYCLES - 1);
    else if (tmr != '0)           tmr <= tmr - 1'b1;
  end

  assign timeout = ((state == DDR_CMD) || (state == DDR_RD)) && (tmr == '0);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next    = state;
    memory_busy   = 1'b1;
    ddr_cmd_valid = 1'b0;
    unique case (state)
      IDLE: begin
        memory_busy = 1'b0;
        if (req_one) state_next = memory_addr[LOCAL_SEL_BIT] ? LOCAL : DDR_CMD;
      end
      LOCAL: state_next = IDLE;
      DDR_CMD: begin
        ddr_cmd_valid = 1'b1;
        if (accept)      state_next = we_q ? IDLE : DDR_RD;
        else if (expire) state_next = IDLE;
      end
      DDR_RD: if (rd_done || expire) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q           <= '0;
      wdata_q          <= '0;
      we_q             <= 1'b0;
      memory_data_read <= '0;
    end else begin
      if ((state == IDLE) && req_one) begin
        addr_q  <= memory_addr[DDR_ADDR_W-1:0];
        wdata_q <= memory_data_write;
        we_q    <= memory_write_req;
      end
      if ((state == LOCAL) && !we_q) memory_data_read <= rb_rdata;
      else if (rd_done)              memory_data_read <= ddr_rdata;
      else if (expire && !we_q)      memory_data_read <= TIMEOUT_DATA;
    end
  end

  assign ddr_cmd_addr  = addr_q;
  assign ddr_cmd_we    = we_q;
  assign ddr_cmd_wdata = wdata_q;

  assign txn_done  = (state == LOCAL) | (accept & we_q) | rd_done;
  assign set_error = ((state == IDLE) & req_both) | expire;

  mem_bus_regbank #(
    .REG_COUNT (REG_COUNT),
    .IDX_W     (IDX_W)
  ) u_regbank (
    .clk       (clk),
    .reset     (reset),
    .wr_en     ((state == LOCAL) & we_q),
    .idx       (addr_q[IDX_W-1:0]),
    .wdata     (wdata_q),
    .txn_done  (txn_done),
    .set_error (set_error),
    .rdata     (rb_rdata),
    .led_reg   (led_reg),
    .bus_error (bus_error)
  );

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: expected completions are queued at issue
// and checked by a monitor on each falling edge of memory_busy.
module tb_mem_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_read_req, memory_write_req;
  logic [25:0] memory_addr;
  logic [31:0] memory_data_write, memory_data_read;
  logic        memory_busy;
  logic        ddr_cmd_valid, ddr_cmd_ready, ddr_cmd_we;
  logic [24:0] ddr_cmd_addr;
  logic [31:0] ddr_cmd_wdata, ddr_rdata;
  logic        ddr_rdata_valid;
  logic [3:0]  led_reg;
  logic        bus_error;

  mem_bus_responder dut (
    .clk               (clk),
    .reset             (reset),
    .memory_read_req   (memory_read_req),
    .memory_write_req  (memory_write_req),
    .memory_addr       (memory_addr),
    .memory_data_write (memory_data_write),
    .memory_data_read  (memory_data_read),
    .memory_busy       (memory_busy),
    .ddr_cmd_valid     (ddr_cmd_valid),
    .ddr_cmd_ready     (ddr_cmd_ready),
    .ddr_cmd_we        (ddr_cmd_we),
    .ddr_cmd_addr      (ddr_cmd_addr),
    .ddr_cmd_wdata     (ddr_cmd_wdata),
    .ddr_rdata         (ddr_rdata),
    .ddr_rdata_valid   (ddr_rdata_valid),
    .led_reg           (led_reg),
    .bus_error         (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          busy;
    int          tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_resp(input logic [31:0] data, input int busy, input int tag);
    exp_t e;
    e.data = data;
    e.busy = busy;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [25:0] a, input logic [31:0] d);
    memory_read_req   = rd;
    memory_write_req  = wr;
    memory_addr       = a;
    memory_data_write = d;
    step();
    memory_read_req  = 1'b0;
    memory_write_req = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (memory_busy && n < limit) begin
      step();
      n++;
    end
    check("idle_bound", {31'd0, memory_busy}, 32'd0);
  endtask

  // Monitor: a busy period that ends without reset is one completed transaction.
  always @(negedge clk) begin
    if (reset) busy_cnt = 0;
    else if (memory_busy) busy_cnt++;
    else if (busy_cnt != 0) begin
      if (sb.size() == 0) check("unexpected_resp", 32'(busy_cnt), 32'd0);
      else begin
        mon_e = sb.pop_front();
        check($sformatf("busy_len#%0d", mon_e.tag), 32'(busy_cnt), 32'(mon_e.busy));
        check($sformatf("rdata#%0d", mon_e.tag), memory_data_read, mon_e.data);
      end
      busy_cnt = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    memory_read_req = 1'b0; memory_write_req = 1'b0;
    memory_addr = '0; memory_data_write = '0;
    ddr_cmd_ready = 1'b0; ddr_rdata = '0; ddr_rdata_valid = 1'b0;
    step(); step();
    check("rst_busy",  {31'd0, memory_busy}, 32'd0);
    check("rst_valid", {31'd0, ddr_cmd_valid}, 32'd0);
    check("rst_rdata", memory_data_read, 32'd0);
    check("rst_led",   {28'd0, led_reg}, 32'd0);
    check("rst_err",   {31'd0, bus_error}, 32'd0);
    reset = 1'b0;
    step();

    // local write then read of register 1
    expect_resp(32'h0000_0000, 1, 1);
    issue(1'b0, 1'b1, 26'h2000001, 32'h1234_5678);
    wait_idle(10);
    expect_resp(32'h1234_5678, 1, 2);
    issue(1'b1, 1'b0, 26'h2000001, 32'h0);
    wait_idle(10);

    // LED register
    expect_resp(32'h1234_5678, 1, 3);
    issue(1'b0, 1'b1, 26'h2000000, 32'h0000_000A);
    wait_idle(10);
    check("led_after_write", {28'd0, led_reg}, 32'h0000_000A);

    // status: 3 completed transactions so far, no error
    expect_resp(32'h0003_0000, 1, 4);
    issue(1'b1, 1'b0, 26'h2000007, 32'h0);
    wait_idle(10);

    // DDR read with 3 cycles of backpressure, data 2 cycles after accept
    expect_resp(32'hCAFE_F00D, 7, 5);
    issue(1'b1, 1'b0, 26'h0000100, 32'h0);
    memory_addr = 26'h1555555;
    for (int i = 0; i < 3; i++) begin
      check("ddr_valid_wait", {31'd0, ddr_cmd_valid}, 32'd1);
      check("ddr_addr_stable", {7'd0, ddr_cmd_addr}, 32'h0000_0100);
      check("ddr_we_read", {31'd0, ddr_cmd_we}, 32'd0);
      step();
    end
    ddr_cmd_ready = 1'b1;
    step();
    ddr_cmd_ready = 1'b0;
    check("ddr_valid_after_accept", {31'd0, ddr_cmd_valid}, 32'd0);
    step(); step();
    ddr_rdata = 32'hCAFE_F00D; ddr_rdata_valid = 1'b1;
    step();
    ddr_rdata_valid = 1'b0;
    wait_idle(5);

    // DDR write accepted immediately; read data must be unchanged
    ddr_cmd_ready = 1'b1;
    expect_resp(32'hCAFE_F00D, 1, 6);
    issue(1'b0, 1'b1, 26'h0000200, 32'h0000_55AA);
    check("ddr_we_write", {31'd0, ddr_cmd_we}, 32'd1);
    check("ddr_wdata", ddr_cmd_wdata, 32'h0000_55AA);
    check("ddr_waddr", {7'd0, ddr_cmd_addr}, 32'h0000_0200);
    step();
    ddr_cmd_ready = 1'b0;
    wait_idle(5);

    // simultaneous read and write: rejected, error flagged
    issue(1'b1, 1'b1, 26'h0000300, 32'h0);
    check("both_busy",  {31'd0, memory_busy}, 32'd0);
    check("both_valid", {31'd0, ddr_cmd_valid}, 32'd0);
    check("both_err",   {31'd0, bus_error}, 32'd1);
    step();
    check("both_valid_later", {31'd0, ddr_cmd_valid}, 32'd0);

    expect_resp(32'h0006_0001, 1, 7);
    issue(1'b1, 1'b0, 26'h2000007, 32'h0);
    wait_idle(10);
    expect_resp(32'h0006_0001, 1, 8);
    issue(1'b0, 1'b1, 26'h2000007, 32'hFFFF_FFFF);
    wait_idle(10);
    check("err_cleared", {31'd0, bus_error}, 32'd0);
    expect_resp(32'h0000_0000, 1, 9);
    issue(1'b1, 1'b0, 26'h2000007, 32'h0);
    wait_idle(10);

    // request while busy is ignored
    expect_resp(32'h0BAD_F00D, 3, 10);
    issue(1'b1, 1'b0, 26'h0000300, 32'h0);
    memory_write_req = 1'b1; memory_addr = 26'h2000001; memory_data_write = 32'h0000_0BAD;
    step();
    memory_write_req = 1'b0;
    check("busy_req_addr", {7'd0, ddr_cmd_addr}, 32'h0000_0300);
    ddr_cmd_ready = 1'b1;
    step();
    ddr_cmd_ready = 1'b0;
    ddr_rdata = 32'h0BAD_F00D; ddr_rdata_valid = 1'b1;
    step();
    ddr_rdata_valid = 1'b0;
    wait_idle(5);
    step();
    check("busy_req_no_second", {31'd0, memory_busy}, 32'd0);
    // aliased address: upper index bits ignored, register 1 untouched
    expect_resp(32'h1234_5678, 1, 11);
    issue(1'b1, 1'b0, 26'h3FFFFF9, 32'h0);
    wait_idle(10);

    // reset while in DDR_RD
    ddr_cmd_ready = 1'b1;
    issue(1'b1, 1'b0, 26'h0000400, 32'h0);
    step();
    ddr_cmd_ready = 1'b0;
    check("pre_reset_busy", {31'd0, memory_busy}, 32'd1);
    reset = 1'b1;
    step();
    check("rst_mid_busy",  {31'd0, memory_busy}, 32'd0);
    check("rst_mid_valid", {31'd0, ddr_cmd_valid}, 32'd0);
    reset = 1'b0;
    ddr_rdata = 32'h9999_9999; ddr_rdata_valid = 1'b1;
    step();
    ddr_rdata_valid = 1'b0;
    check("late_rdata_ignored", memory_data_read, 32'd0);
    check("late_rdata_busy", {31'd0, memory_busy}, 32'd0);
    check("rst_mid_led", {28'd0, led_reg}, 32'd0);

`ifdef BUS_TIMEOUT_EN
    expect_resp(32'hDEAD_BEEF, 1024, 12);
    issue(1'b1, 1'b0, 26'h0000500, 32'h0);
    wait_idle(1100);
    check("timeout_err", {31'd0, bus_error}, 32'd1);
    check("timeout_valid", {31'd0, ddr_cmd_valid}, 32'd0);
`endif

    step(); step();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_responder.md
Name: mem_bus_responder

Overview:
- Responder end of the processor memory interface driven by control_unit: it answers memory_read_req and memory_write_req with memory_busy and memory_data_read.
- Lives inside hal.
- Decodes the 26-bit word address into two targets:
  - an on-chip register bank, which drives the LEDs and holds scratch and status words;
  - a valid/ready command port toward the DDR controller wrapper.
- Enforces one outstanding transaction at a time.

Parameters:
- REG_COUNT, 8, number of 32-bit local registers (power of two, minimum 4).
- DDR_ADDR_W, 25, width of the DDR word address.
- TIMEOUT_CYCLES, 1024, DDR wait limit; used only when BUS_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- memory_read_req  in  1  read request strobe.
- memory_write_req  in  1  write request strobe.
- memory_addr  in  26  word address; bit 25 = 1 selects local registers, 0 selects DDR.
- memory_data_write  in  32  write data.
- memory_data_read  out  32  read data.
- memory_busy  out  1  transaction in progress.
- ddr_cmd_valid  out  1  DDR command valid.
- ddr_cmd_ready  in  1  DDR command accepted.
- ddr_cmd_we  out  1  1 = write, 0 = read.
- ddr_cmd_addr  out  DDR_ADDR_W  DDR word address.
- ddr_cmd_wdata  out  32  DDR write data.
- ddr_rdata  in  32  DDR read data.
- ddr_rdata_valid  in  1  one-cycle DDR read-data strobe.
- led_reg  out  4  bits [3:0] of local register 0.
- bus_error  out  1  sticky error flag.

Behaviour:
- Reset values:
  - all outputs are 0;
  - memory_data_read is 0;
  - all local registers are 0;
  - the state machine is in IDLE.
- Request sampling: requests are sampled only in IDLE with memory_busy low. Address and data are captured on that cycle, and memory_busy goes high on the next cycle.
- Requests arriving while memory_busy is high are ignored. They are not queued.
- If read and write are asserted in the same sampled cycle:
  - no access is performed;
  - bus_error is set;
  - memory_busy stays low.
- States:
  - IDLE -> LOCAL when the address is local.
  - IDLE -> DDR_CMD when the address is DDR.
  - LOCAL -> IDLE after exactly 1 cycle.
  - DDR_CMD -> IDLE on a write accept (ddr_cmd_valid and ddr_cmd_ready both high).
  - DDR_CMD -> DDR_RD on a read accept.
  - DDR_RD -> IDLE on ddr_rdata_valid.
- memory_busy is high in every state except IDLE.
- Local accesses:
  - register index = memory_addr[log2(REG_COUNT)-1:0]; address bits above the index and below bit 25 are ignored;
  - total latency: memory_busy is high for exactly 1 cycle;
  - a write updates the register in the LOCAL cycle;
  - a read loads memory_data_read in the LOCAL cycle.
- Special local registers:
  - register REG_COUNT-1 is read-only status: bit 0 = bus_error, bits [31:16] = saturating count of completed transactions;
  - a write to the status register clears bus_error and the count, regardless of the data;
  - register 0 drives led_reg.
- DDR path:
  - ddr_cmd_valid is high only in DDR_CMD;
  - addr, we and wdata are held stable until accept;
  - ddr_cmd_addr = memory_addr[DDR_ADDR_W-1:0].
- Read data:
  - memory_data_read is updated on the ddr_rdata_valid cycle, and memory_busy falls on the following cycle;
  - memory_data_read holds its value until the next completed read; writes leave it unchanged.
- ddr_rdata_valid outside DDR_RD is ignored.
- Reset asserted mid-transaction returns the block to IDLE immediately; the pending DDR command is dropped.

Optional Feature:
- BUS_TIMEOUT_EN, defined:
  - a cycle counter runs in DDR_CMD and DDR_RD;
  - when TIMEOUT_CYCLES is reached, the block moves to IDLE, deasserts ddr_cmd_valid, sets bus_error, and loads memory_data_read = 32'hDEAD_BEEF on read timeouts;
  - the counter clears on every state entry.
- BUS_TIMEOUT_EN, undefined: no counter; the block waits indefinitely for the DDR side.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state enum (IDLE, LOCAL, DDR_CMD, DDR_RD);
  - LOCAL_SEL_BIT = 25;
  - STATUS_REG_IDX;
  - TIMEOUT_DATA = 32'hDEAD_BEEF.
- One natural sub-module: mem_bus_regbank, which holds the local register file, the status register, the transaction counter and led_reg.

Test Plan:
- Local write, then local read:
  - write addr 26'h2000001, data 32'h12345678, then read the same address;
  - memory_busy is high for 1 cycle each time, and memory_data_read = 32'h12345678.
- LED register:
  - write 32'h0000000A to 26'h2000000;
  - led_reg = 4'hA the cycle after LOCAL.
- DDR read with backpressure:
  - read addr 26'h0000100, hold ddr_cmd_ready low for 3 cycles, then return ddr_rdata 32'hCAFEF00D 2 cycles after accept;
  - ddr_cmd_addr = 25'h100 and stable throughout, memory_data_read = 32'hCAFEF00D, memory_busy is high for 7 cycles.
- Illegal and busy requests:
  - assert both read and write: no DDR command is issued, bus_error = 1;
  - then write the status register: bus_error = 0;
  - a request during busy: no second transaction.
- Reset mid-read:
  - assert reset while in DDR_RD;
  - next cycle memory_busy = 0 and ddr_cmd_valid = 0;
  - a late ddr_rdata_valid is ignored.
- BUS_TIMEOUT_EN defined, ddr_cmd_ready never asserted:
  - after 1024 cycles memory_busy falls, memory_data_read = 32'hDEAD_BEEF, bus_error = 1.
